// File: rtl/mega_flash.sv
// mega_flash: 16-bit program flash with a registered fetch port and a byte-wide LPM read port.
// Define MEGA_FLASH_SPM_EN to add the self-programming page buffer and erase/write sequencer.
module mega_flash #(
  parameter int    ADDR_ROM_BUS_WIDTH = 14,
  parameter string ROM_PATH           = "",
  parameter int    PAGE_LOG2          = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_ROM_BUS_WIDTH-1:0] a,
  output logic [15:0]                   d,
  input  logic [ADDR_ROM_BUS_WIDTH:0]   lpm_a,
  input  logic                          lpm_rd,
  output logic [7:0]                    lpm_d,
  output logic                          lpm_valid,
  input  logic                          spm_req,
  input  logic [1:0]                    spm_op,
  input  logic [ADDR_ROM_BUS_WIDTH-1:0] spm_a,
  input  logic [15:0]                   spm_wd,
  output logic                          busy
);
  localparam int AW    = ADDR_ROM_BUS_WIDTH;
  localparam int DEPTH = 1 << AW;

  if (PAGE_LOG2 < 1 || PAGE_LOG2 > ADDR_ROM_BUS_WIDTH - 1) begin : g_page_range
    $error("mega_flash: PAGE_LOG2 out of range");
  end

  logic [15:0] mem [DEPTH];
  logic        spm_busy;
  logic [15:0] lpm_word;

  assign lpm_word = mem[lpm_a[AW:1]];
  assign busy     = spm_busy;

  // Read ports: LPM reads are refused while the sequencer owns the array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d         <= '0;
      lpm_d     <= '0;
      lpm_valid <= 1'b0;
    end else begin
      d         <= mem[a];
      lpm_valid <= lpm_rd & ~spm_busy;
      if (lpm_rd && !spm_busy) lpm_d <= lpm_a[0] ? lpm_word[15:8] : lpm_word[7:0];
    end
  end

`ifdef MEGA_FLASH_SPM_EN
  localparam int PW  = 1 << PAGE_LOG2;
  localparam int PBW = AW - PAGE_LOG2;

  localparam logic [1:0] OP_FILL  = 2'd0;
  localparam logic [1:0] OP_ERASE = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;
  localparam logic [PAGE_LOG2-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, ERASE = 2'd1, WRITE = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [PAGE_LOG2-1:0] cnt;
  logic [PBW-1:0]       page;
  logic [15:0]          page_buf [PW];
  logic                 idle_req;
  logic                 last;
  logic                 we;
  logic [AW-1:0]        wa;
  logic [15:0]          wd;

  assign idle_req = spm_req && (state == IDLE);
  assign last     = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (spm_req && spm_op == OP_ERASE)      state_nxt = ERASE;
        else if (spm_req && spm_op == OP_WRITE) state_nxt = WRITE;
      end
      ERASE, WRITE: if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address is page base concatenated with the counter, so it never crosses a page.
  always_comb begin
    spm_busy = (state != IDLE);
    we       = spm_busy;
    wa       = {page, cnt};
    wd       = (state == WRITE) ? page_buf[cnt] : 16'hFFFF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               cnt <= '0;
    else if (state != IDLE) cnt <= cnt + 1'b1;
    else                    cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE) page <= spm_a[AW-1:PAGE_LOG2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PW; i++) page_buf[i] <= 16'hFFFF;
    end else if ((idle_req && spm_op == OP_CLEAR) || (state == WRITE && last)) begin
      for (int i = 0; i < PW; i++) page_buf[i] <= 16'hFFFF;
    end else if (idle_req && spm_op == OP_FILL) begin
      page_buf[spm_a[PAGE_LOG2-1:0]] <= spm_wd;
    end
  end

  // Unreset write port; nonblocking update gives read-before-write on both read ports.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
`else
  logic spm_unused;
  assign spm_unused = ^{spm_req, spm_op, spm_a, spm_wd};
  assign spm_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_mega_flash.sv
// Randomized bench for mega_flash against a transaction-level memory model; builds with or
// without MEGA_FLASH_SPM_EN to match the design.
module tb_mega_flash;
  localparam int AW    = 10;
  localparam int PL    = 6;
  localparam int PW    = 1 << PL;
  localparam int DEPTH = 1 << AW;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic [AW-1:0] a       = '0;
  logic [15:0]   d;
  logic [AW:0]   lpm_a   = '0;
  logic          lpm_rd  = 1'b0;
  logic [7:0]    lpm_d;
  logic          lpm_valid;
  logic          spm_req = 1'b0;
  logic [1:0]    spm_op  = 2'd0;
  logic [AW-1:0] spm_a   = '0;
  logic [15:0]   spm_wd  = '0;
  logic          busy;

  mega_flash #(.ADDR_ROM_BUS_WIDTH(AW), .ROM_PATH(""), .PAGE_LOG2(PL)) dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .lpm_a(lpm_a), .lpm_rd(lpm_rd), .lpm_d(lpm_d),
    .lpm_valid(lpm_valid), .spm_req(spm_req), .spm_op(spm_op), .spm_a(spm_a),
    .spm_wd(spm_wd), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: memory contents, which words are defined, and the pending page operation.
  logic [15:0] mem_m [DEPTH];
  bit          known [DEPTH];
  int          op_kind = 0;
  int          edge_no = 0;
`ifdef MEGA_FLASH_SPM_EN
  logic [15:0] buf_m [PW];
  int          op_start = 0;
  int          op_base  = 0;
`endif
  logic [15:0] exp_d      = '0;
  bit          exp_d_ok   = 1'b0;
  logic [7:0]  exp_lpm_d  = '0;
  bit          exp_lpm_ok = 1'b0;
  bit          exp_valid  = 1'b0;
  bit          exp_busy   = 1'b0;
  bit          chk_en     = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    op_kind = 0;
`ifdef MEGA_FLASH_SPM_EN
    for (int i = 0; i < PW; i++) buf_m[i] = 16'hFFFF;
`endif
    exp_d = '0; exp_d_ok = 1'b1; exp_lpm_d = '0; exp_lpm_ok = 1'b1;
    exp_valid = 1'b0; exp_busy = 1'b0;
  endtask

  // One rising edge: reads see the array before any write landing on this edge.
  task automatic model_step();
    logic [15:0]   w;
    logic [AW-1:0] wi;
    bit            was_busy;
    int            k;
    was_busy  = (op_kind != 0);
    exp_d     = mem_m[a];
    exp_d_ok  = known[a];
    exp_valid = lpm_rd && !was_busy;
    if (exp_valid) begin
      wi         = lpm_a[AW:1];
      w          = mem_m[wi];
      exp_lpm_ok = known[wi];
      exp_lpm_d  = lpm_a[0] ? w[15:8] : w[7:0];
    end
`ifdef MEGA_FLASH_SPM_EN
    if (was_busy) begin
      k  = edge_no - op_start - 1;
      wi = AW'(op_base + k);
      mem_m[wi] = (op_kind == 1) ? 16'hFFFF : buf_m[PL'(k)];
      known[wi] = 1'b1;
      if (k == PW - 1) begin
        if (op_kind == 2) for (int i = 0; i < PW; i++) buf_m[i] = 16'hFFFF;
        op_kind = 0;
      end
    end else if (spm_req) begin
      case (spm_op)
        2'd0: buf_m[PL'(int'(spm_a) % PW)] = spm_wd;
        2'd1, 2'd2: begin
          op_kind  = int'(spm_op);
          op_start = edge_no;
          op_base  = int'(spm_a) - int'(spm_a) % PW;
        end
        default: for (int i = 0; i < PW; i++) buf_m[i] = 16'hFFFF;
      endcase
    end
    exp_busy = (op_kind != 0);
`endif
    edge_no++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 16'(busy), 16'(exp_busy));
      chk("lpm_valid", 16'(lpm_valid), 16'(exp_valid));
      if (exp_valid && exp_lpm_ok) chk("lpm_d", 16'(lpm_d), 16'(exp_lpm_d));
      if (exp_d_ok) chk("d", d, exp_d);
    end
  end

  task automatic cycle();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_reads();
    a      = AW'($urandom_range(0, DEPTH - 1));
    lpm_a  = (AW + 1)'($urandom_range(0, 2 * DEPTH - 1));
    lpm_rd = 1'($urandom_range(0, 1));
  endtask

  task automatic spm_cmd(input logic [1:0] op, input int addr, input logic [15:0] wd);
    spm_req = 1'b1; spm_op = op; spm_a = AW'(addr); spm_wd = wd;
    cycle();
    spm_req = 1'b0;
  endtask

  task automatic fetch_chk(input int addr, input logic [15:0] exp, input string name);
    a = AW'(addr); lpm_rd = 1'b0;
    cycle();
    chk(name, d, exp);
  endtask

  task automatic run_busy(input bit inject, output int n);
    n = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      n++;
      rand_reads();
      spm_req = 1'b0;
      if (inject && i == 5) begin
        spm_req = 1'b1; spm_op = 2'd1; spm_a = '0; lpm_rd = 1'b1;
      end
      cycle();
      if (inject && i == 5) chk("lpm_dropped_while_busy", 16'(lpm_valid), 16'd0);
    end
    spm_req = 1'b0;
  endtask

  task automatic page_op(input logic [1:0] op, input int addr, input bit inject, input string name);
    int n;
    spm_cmd(op, addr, 16'h0000);
    run_busy(inject, n);
    chk(name, 16'(n), 16'(PW));
  endtask

  initial begin
`ifndef MEGA_FLASH_SPM_EN
    for (int i = 0; i < DEPTH; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if (i == 16'h0010) v = 16'h940C;
      if (i == 16'h0020) v = 16'hABCD;
      dut.mem[i] = v;
      mem_m[i]   = v;
      known[i]   = 1'b1;
    end
`endif
    #1 rst = 1'b0;
    model_reset();
    repeat (3) cycle();
    chk("reset_d", d, 16'h0000);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_lpm_valid", 16'(lpm_valid), 16'd0);
    chk("reset_lpm_d", 16'(lpm_d), 16'd0);
    chk_en = 1'b1;
    rst = 1'b1;
    cycle();

`ifdef MEGA_FLASH_SPM_EN
    for (int p = 0; p < DEPTH / PW; p++) page_op(2'd1, p * PW, 1'b0, "erase_all_busy_len");
    spm_cmd(2'd0, 16'h0010, 16'h940C);
    spm_cmd(2'd0, 16'h0020, 16'hABCD);
    page_op(2'd2, 16'h0000, 1'b0, "write_page0_busy_len");
`endif
    fetch_chk(16'h0010, 16'h940C, "fetch_0010");
    lpm_rd = 1'b1; lpm_a = 11'h041;
    cycle();
    chk("lpm_valid_hi", 16'(lpm_valid), 16'd1);
    chk("lpm_d_0041", 16'(lpm_d), 16'h00AB);
    lpm_a = 11'h040;
    cycle();
    chk("lpm_d_0040", 16'(lpm_d), 16'h00CD);
    lpm_rd = 1'b0;
    cycle();
    chk("lpm_valid_lo", 16'(lpm_valid), 16'd0);

`ifdef MEGA_FLASH_SPM_EN
    for (int i = 0; i < PW; i++) spm_cmd(2'd0, 16'h0040 + i, 16'(16'h1000 + i));
    page_op(2'd1, 16'h0040, 1'b0, "erase_busy_len");
    page_op(2'd2, 16'h0040, 1'b1, "write_busy_len_with_ignored_req");
    for (int i = 0; i < PW; i++) fetch_chk(16'h0040 + i, 16'(16'h1000 + i), "page40_word");

    for (int i = 0; i < PW; i++) spm_cmd(2'd0, i, 16'(16'h2000 + i));
    page_op(2'd2, 16'h00C0, 1'b0, "write_c0_busy_len");
    page_op(2'd2, 16'h00C0, 1'b0, "rewrite_c0_busy_len");
    for (int i = 0; i < PW; i += 9) fetch_chk(16'h00C0 + i, 16'hFFFF, "buffer_reset_after_write");

    for (int i = 0; i < PW; i++) spm_cmd(2'd0, i, 16'(16'h7000 + i));
    page_op(2'd2, 16'h0100, 1'b0, "write_100_busy_len");
    for (int i = 0; i < 4; i++) spm_cmd(2'd0, i, 16'h5A5A);
    spm_cmd(2'd3, 16'h0000, 16'h0000);
    chk("clear_not_busy", 16'(busy), 16'd0);
    page_op(2'd2, 16'h0100, 1'b0, "write_cleared_busy_len");
    for (int i = 0; i < 4; i++) fetch_chk(16'h0100 + i, 16'hFFFF, "clear_word");

    for (int i = 0; i < PW; i++) spm_cmd(2'd0, i, 16'(16'h4000 + i));
    page_op(2'd2, 16'h0140, 1'b0, "write_140_busy_len");
    for (int i = 0; i < PW; i++) spm_cmd(2'd0, 16'h0080 + i, 16'(16'h3000 + i));
    spm_cmd(2'd2, 16'h0080, 16'h0000);
    repeat (10) cycle();
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_reset_busy", 16'(busy), 16'd0);
    chk("async_reset_d", d, 16'h0000);
    chk("async_reset_lpm_valid", 16'(lpm_valid), 16'd0);
    cycle();
    rst = 1'b1;
    for (int i = 0; i < 16; i++)
      fetch_chk(16'h0080 + i, (i < 10) ? 16'(16'h3000 + i) : 16'hFFFF, "interrupted_write_word");
    page_op(2'd2, 16'h0140, 1'b0, "write_after_reset_busy_len");
    fetch_chk(16'h0140, 16'hFFFF, "buffer_reset_by_rst_lo");
    fetch_chk(16'h017F, 16'hFFFF, "buffer_reset_by_rst_hi");
`else
    spm_cmd(2'd0, 16'h0040, 16'h1234);
    spm_cmd(2'd2, 16'h0040, 16'h0000);
    chk("no_spm_busy_after_write", 16'(busy), 16'd0);
    spm_cmd(2'd1, 16'h0000, 16'h0000);
    repeat (70) begin
      rand_reads();
      cycle();
    end
    chk("no_spm_busy_later", 16'(busy), 16'd0);
    fetch_chk(16'h0010, 16'h940C, "no_spm_mem_unchanged");
`endif

    for (int i = 0; i < 3000; i++) begin
      int r;
      rand_reads();
      r       = $urandom_range(0, 15);
      spm_req = (r < 4);
      r       = $urandom_range(0, 9);
      spm_op  = (r < 6) ? 2'd0 : (r < 8) ? 2'd2 : (r == 8) ? 2'd1 : 2'd3;
      spm_a   = AW'($urandom);
      spm_wd  = 16'($urandom);
      cycle();
    end
    spm_req = 1'b0;
    lpm_rd  = 1'b0;
    repeat (70) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
